// File: rtl/shading_pipe.sv
// Lambertian shading: vec3 normal . light -> ambient-lifted intensity -> packed RGB pixel, tag carried alongside.
// Latency: fixed 4 pipeline-advance cycles from input accept to valid_out; 1 beat/cycle with ready_in held high.
// Backpressure: whole pipe stalls when valid_out && !ready_in; ready_out = !valid_out || ready_in.
module shading_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 24,
    parameter int OUT_WIDTH  = 24,
    parameter int TAG_WIDTH  = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    output logic                    ready_out,
    input  logic                    hit_in,
    input  logic [3*DATA_WIDTH-1:0] normal_vec,
    input  logic [3*DATA_WIDTH-1:0] light_vec,
    input  logic [TAG_WIDTH-1:0]    tag_in,
    input  logic [7:0]              ambient_lvl,
    input  logic [OUT_WIDTH-1:0]    base_color,
    input  logic [OUT_WIDTH-1:0]    bg_color,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic [OUT_WIDTH-1:0]    shade_out,
    output logic [TAG_WIDTH-1:0]    tag_out
);

    localparam int CH_W = OUT_WIDTH / 3;
    localparam int PW   = 2 * DATA_WIDTH;
    localparam int SW   = 2 * DATA_WIDTH + 2;
    localparam logic signed [SW-1:0] ONE_FX = SW'(1) <<< FRAC_BITS;

    typedef struct packed {
        logic                 hit;
        logic [TAG_WIDTH-1:0] tag;
        logic [OUT_WIDTH-1:0] base;
        logic [OUT_WIDTH-1:0] bg;
    } meta_t;

    logic adv;
    logic v1, v2, v3;
    meta_t m_in, m1, m2, m3;
    logic [7:0] amb1, amb2;

    logic signed [DATA_WIDTH-1:0] nx, ny, nz, lx, ly, lz;
    logic signed [PW-1:0] px, py, pz;
    logic signed [SW-1:0] sum_c, dot_c;
    logic [8:0]  d9_c, d9;
    logic [16:0] scaled_c;
    logic [7:0]  inten_c;
    logic [8:0]  i9_c, i9;
    logic [OUT_WIDTH-1:0] shade_c;

    assign adv       = !valid_out || ready_in;
    assign ready_out = adv;

    assign nx = normal_vec[3*DATA_WIDTH-1 -: DATA_WIDTH];
    assign ny = normal_vec[2*DATA_WIDTH-1 -: DATA_WIDTH];
    assign nz = normal_vec[DATA_WIDTH-1   -: DATA_WIDTH];
    assign lx = light_vec[3*DATA_WIDTH-1 -: DATA_WIDTH];
    assign ly = light_vec[2*DATA_WIDTH-1 -: DATA_WIDTH];
    assign lz = light_vec[DATA_WIDTH-1   -: DATA_WIDTH];

    assign m_in = '{hit: hit_in, tag: tag_in, base: base_color, bg: bg_color};

    // Two guard bits keep the three-way sum exact for any in-range inputs.
    always_comb begin
        sum_c = SW'(px) + SW'(py) + SW'(pz);
        dot_c = sum_c >>> FRAC_BITS;
        d9_c  = '0;
        if (dot_c < 0) begin
            d9_c = 9'd0;
        end else if (dot_c >= ONE_FX) begin
            d9_c = 9'd256;
        end else begin
            d9_c = 9'(dot_c >>> (FRAC_BITS - 8));
        end
    end

    // Rounding bump makes full intensity (255) an exact unity gain of 256.
    always_comb begin
        scaled_c = 17'(8'd255 - amb2) * 17'(d9);
        inten_c  = amb2 + 8'(scaled_c >> 8);
        i9_c     = {1'b0, inten_c} + 9'(inten_c[7]);
    end

    always_comb begin
        shade_c = m3.bg;
        if (m3.hit) begin
            for (int c = 0; c < 3; c++) begin
                shade_c[c*CH_W +: CH_W] =
                    CH_W'(((CH_W+9)'(m3.base[c*CH_W +: CH_W]) * (CH_W+9)'(i9)) >> 8);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            valid_out <= 1'b0;
            shade_out <= '0;
            tag_out   <= '0;
        end else if (adv) begin
            v1        <= valid_in;
            v2        <= v1;
            v3        <= v2;
            valid_out <= v3;
            if (v3) begin
                shade_out <= shade_c;
                tag_out   <= m3.tag;
            end
        end
    end

    // Datapath registers only load behind a valid beat; bubbles leave them untouched.
    always_ff @(posedge clk) begin
        if (adv) begin
            if (valid_in) begin
                px   <= PW'(nx) * PW'(lx);
                py   <= PW'(ny) * PW'(ly);
                pz   <= PW'(nz) * PW'(lz);
                m1   <= m_in;
                amb1 <= ambient_lvl;
            end
            if (v1) begin
                d9   <= d9_c;
                m2   <= m1;
                amb2 <= amb1;
            end
            if (v2) begin
                i9 <= i9_c;
                m3 <= m2;
            end
        end
    end

endmodule

// File: tb/tb_shading_pipe.sv
// Bench for shading_pipe: directed boundary cases plus randomized streams against a behavioural shading model.
module tb_shading_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic        hit_in = 1'b0;
    logic [95:0] normal_vec = '0;
    logic [95:0] light_vec = '0;
    logic [19:0] tag_in = '0;
    logic [7:0]  ambient_lvl = 8'd26;
    logic [23:0] base_color = 24'hFFFFFF;
    logic [23:0] bg_color = 24'h000000;
    logic        valid_out;
    logic        ready_in = 1'b1;
    logic [23:0] shade_out;
    logic [19:0] tag_out;

    int checks = 0;
    int errors = 0;
    logic [43:0] exp_q[$];
    logic [43:0] obs_q[$];

    localparam logic [31:0] ONE  = 32'h0100_0000;
    localparam logic [31:0] MONE = 32'hFF00_0000;
    localparam logic [31:0] TWO  = 32'h0200_0000;
    localparam logic [31:0] MTWO = 32'hFE00_0000;
    localparam logic [31:0] D707 = 32'h00B4_FDF3;
    localparam logic [31:0] ZRO  = 32'h0;

    always #5 clk = ~clk;

    shading_pipe dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out),
        .hit_in(hit_in), .normal_vec(normal_vec), .light_vec(light_vec),
        .tag_in(tag_in), .ambient_lvl(ambient_lvl), .base_color(base_color),
        .bg_color(bg_color), .valid_out(valid_out), .ready_in(ready_in),
        .shade_out(shade_out), .tag_out(tag_out)
    );

    function automatic logic [95:0] vec(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return {x, y, z};
    endfunction

    // Real-number style Lambert model: clamp cosine to [0,1], lift by ambient, scale each channel.
    function automatic logic [23:0] model(input logic hit, input logic [95:0] n, input logic [95:0] l,
                                          input logic [7:0] amb, input logic [23:0] base, input logic [23:0] bg);
        logic signed [71:0] acc;
        int d, a, inten, gain, b;
        logic [23:0] r;
        if (!hit) return bg;
        acc = 0;
        for (int k = 0; k < 3; k++) acc += $signed(n[k*32 +: 32]) * $signed(l[k*32 +: 32]);
        acc = acc >>> 24;
        if (acc < 0) d = 0;
        else if (acc >= 72'sd16777216) d = 256;
        else d = int'(acc) / 65536;
        a = int'(amb);
        inten = a + ((255 - a) * d) / 256;
        gain = (inten >= 128) ? inten + 1 : inten;
        for (int c = 0; c < 3; c++) begin
            b = int'(base[c*8 +: 8]);
            r[c*8 +: 8] = 8'((b * gain) / 256);
        end
        return r;
    endfunction

    function automatic logic [31:0] rnd_comp();
        int m;
        logic [31:0] v;
        m = int'($urandom_range(0, 3));
        case (m)
            0: v = 32'($urandom_range(0, 33554432)) - ONE;
            1: begin
                v = $urandom;
                if (v == 32'h8000_0000) v = 32'h8000_0001;
            end
            2: v = ONE;
            default: v = ZRO;
        endcase
        return v;
    endfunction

    task automatic randomize_beat();
        hit_in      = ($urandom_range(0, 3) != 0);
        normal_vec  = vec(rnd_comp(), rnd_comp(), rnd_comp());
        light_vec   = vec(rnd_comp(), rnd_comp(), rnd_comp());
        ambient_lvl = 8'($urandom_range(0, 255));
        base_color  = 24'($urandom);
        bg_color    = 24'($urandom);
    endtask

    // One clock of traffic: record accepted beats (with model expectation) and emitted beats.
    task automatic cycle();
        #1;
        if (valid_in && ready_out)
            exp_q.push_back({tag_in, model(hit_in, normal_vec, light_vec, ambient_lvl, base_color, bg_color)});
        if (valid_out && ready_in)
            obs_q.push_back({tag_out, shade_out});
        @(posedge clk);
        #1;
    endtask

    // Single beat into an idle pipe; lat counts clock edges until valid_out (-1 if never).
    task automatic send_one(input logic h, input logic [95:0] n, input logic [95:0] l, input logic [19:0] t,
                            output logic [23:0] pix, output logic [19:0] tg, output int lat);
        ready_in = 1'b1; valid_in = 1'b1; hit_in = h; normal_vec = n; light_vec = l; tag_in = t;
        @(posedge clk); #1;
        valid_in = 1'b0;
        lat = 1;
        while (!valid_out && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!valid_out) lat = -1;
        pix = shade_out;
        tg  = tag_out;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_in = 1'b0; ready_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out got=%b want=0", valid_out); end
        checks++; if (shade_out !== 24'h0) begin errors++; $display("FAIL reset_shade got=%h want=000000", shade_out); end
        checks++; if (tag_out !== 20'h0) begin errors++; $display("FAIL reset_tag got=%h want=00000", tag_out); end
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready_out got=%b want=1", ready_out); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_diagonal_latency();
        logic [23:0] pix; logic [19:0] tg; int lat;
        ambient_lvl = 8'd26; base_color = 24'hFFFFFF;
        send_one(1'b1, vec(ZRO, D707, D707), vec(ZRO, D707, D707), 20'hABCDE, pix, tg, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL diag_latency got=%0d want=4", lat); end
        checks++; if (pix !== 24'hFEFEFE) begin errors++; $display("FAIL diag_shade got=%h want=FEFEFE", pix); end
        checks++; if (tg !== 20'hABCDE) begin errors++; $display("FAIL diag_tag got=%h want=ABCDE", tg); end
    endtask

    task automatic test_directed_values();
        logic [95:0] nt[8], lt[8];
        logic        ht[8];
        logic [7:0]  at[8];
        logic [23:0] bt[8], et[8];
        logic [23:0] pix; logic [19:0] tg; int lat;
        nt[0] = vec(ZRO, ZRO, ONE);  lt[0] = vec(ZRO, ZRO, ONE);  ht[0] = 1; at[0] = 26;  bt[0] = 24'hFF8040; et[0] = 24'hFF8040;
        nt[1] = vec(ONE, ZRO, ZRO);  lt[1] = vec(ZRO, ONE, ZRO);  ht[1] = 1; at[1] = 26;  bt[1] = 24'hFFFFFF; et[1] = 24'h191919;
        nt[2] = vec(ZRO, ZRO, ONE);  lt[2] = vec(ZRO, ZRO, MONE); ht[2] = 1; at[2] = 26;  bt[2] = 24'hFFFFFF; et[2] = 24'h191919;
        nt[3] = vec(ONE, D707, MONE);lt[3] = vec(D707, ONE, ONE); ht[3] = 0; at[3] = 26;  bt[3] = 24'hFFFFFF; et[3] = 24'h203040;
        nt[4] = vec(ZRO, ZRO, ONE);  lt[4] = vec(ZRO, ZRO, MONE); ht[4] = 1; at[4] = 255; bt[4] = 24'h123456; et[4] = 24'h123456;
        nt[5] = vec(ZRO, ZRO, ONE);  lt[5] = vec(ZRO, ZRO, MONE); ht[5] = 1; at[5] = 0;   bt[5] = 24'hFFFFFF; et[5] = 24'h000000;
        nt[6] = vec(TWO, ZRO, ZRO);  lt[6] = vec(TWO, ZRO, ZRO);  ht[6] = 1; at[6] = 26;  bt[6] = 24'hFF8040; et[6] = 24'hFF8040;
        nt[7] = vec(TWO, ZRO, ZRO);  lt[7] = vec(MTWO, ZRO, ZRO); ht[7] = 1; at[7] = 0;   bt[7] = 24'hFFFFFF; et[7] = 24'h000000;
        bg_color = 24'h203040;
        for (int i = 0; i < 8; i++) begin
            ambient_lvl = at[i]; base_color = bt[i];
            send_one(ht[i], nt[i], lt[i], 20'(i + 16), pix, tg, lat);
            checks++;
            if (pix !== et[i] || tg !== 20'(i + 16) || lat !== 4) begin
                errors++;
                $display("FAIL directed_case%0d got shade=%h tag=%h lat=%0d want shade=%h tag=%h lat=4",
                         i, pix, tg, lat, et[i], 20'(i + 16));
            end
        end
        ambient_lvl = 8'd26; base_color = 24'hFFFFFF;
    endtask

    task automatic test_backpressure();
        int nt = 0;
        logic have_hold = 1'b0;
        logic [43:0] held = '0;
        logic [43:0] o, e;
        exp_q.delete(); obs_q.delete();
        for (int cyc = 0; cyc < 25; cyc++) begin
            ready_in = !(cyc >= 5 && cyc < 10);
            valid_in = (nt < 8);
            tag_in   = 20'(nt);
            randomize_beat();
            #1;
            if (!ready_in && valid_out) begin
                checks++;
                if (ready_out !== 1'b0) begin errors++; $display("FAIL bp_ready_out cyc=%0d got=%b want=0", cyc, ready_out); end
                if (have_hold) begin
                    checks++;
                    if ({tag_out, shade_out} !== held) begin
                        errors++; $display("FAIL bp_hold cyc=%0d got=%h want=%h", cyc, {tag_out, shade_out}, held);
                    end
                end else begin
                    held = {tag_out, shade_out}; have_hold = 1'b1;
                end
            end
            if (valid_in && ready_out) begin
                exp_q.push_back({tag_in, model(hit_in, normal_vec, light_vec, ambient_lvl, base_color, bg_color)});
                nt++;
            end
            if (valid_out && ready_in) obs_q.push_back({tag_out, shade_out});
            @(posedge clk); #1;
        end
        valid_in = 1'b0; ready_in = 1'b1;
        checks++; if (!have_hold) begin errors++; $display("FAIL bp_stall_seen got=0 want=1"); end
        checks++; if (obs_q.size() !== 8) begin errors++; $display("FAIL bp_count got=%0d want=8", obs_q.size()); end
        for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
            o = obs_q[i]; e = exp_q[i];
            checks++;
            if (o[43:24] !== 20'(i) || o !== e) begin
                errors++; $display("FAIL bp_beat%0d got=%h want tag=%0d data=%h", i, o, i, e);
            end
        end
    endtask

    task automatic test_config_sampling();
        logic [43:0] o;
        exp_q.delete(); obs_q.delete();
        ready_in = 1'b1; hit_in = 1'b1; base_color = 24'hFFFFFF;
        normal_vec = vec(ONE, ZRO, ZRO); light_vec = vec(ZRO, ONE, ZRO);
        valid_in = 1'b1; ambient_lvl = 8'd26; tag_in = 20'hA;
        cycle();
        ambient_lvl = 8'd255; tag_in = 20'hB;
        cycle();
        valid_in = 1'b0;
        repeat (8) cycle();
        checks++; if (obs_q.size() !== 2) begin errors++; $display("FAIL cfg_count got=%0d want=2", obs_q.size()); end
        if (obs_q.size() >= 2) begin
            o = obs_q[0];
            checks++; if (o !== {20'hA, 24'h191919}) begin errors++; $display("FAIL cfg_beatA got=%h want=0000a191919", o); end
            o = obs_q[1];
            checks++; if (o !== {20'hB, 24'hFFFFFF}) begin errors++; $display("FAIL cfg_beatB got=%h want=0000bffffff", o); end
        end
        ambient_lvl = 8'd26;
    endtask

    task automatic test_reset_midstream();
        logic [23:0] pix; logic [19:0] tg; int lat;
        ready_in = 1'b1; valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tag_in = 20'(100 + i); randomize_beat();
            @(posedge clk); #1;
        end
        valid_in = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_flush cyc=%0d got=%b want=0", i, valid_out); end
            @(posedge clk); #1;
        end
        ambient_lvl = 8'd26; base_color = 24'hFFFFFF;
        send_one(1'b1, vec(ONE, ZRO, ZRO), vec(ZRO, ONE, ZRO), 20'h55, pix, tg, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL rst_first_latency got=%0d want=4", lat); end
        checks++; if (pix !== 24'h191919 || tg !== 20'h55) begin
            errors++; $display("FAIL rst_first_beat got=%h/%h want=191919/00055", pix, tg);
        end
    endtask

    task automatic test_random_stream();
        logic [43:0] o, e;
        exp_q.delete(); obs_q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            valid_in = ($urandom_range(0, 3) != 0);
            ready_in = ($urandom_range(0, 3) != 0);
            tag_in   = 20'($urandom);
            randomize_beat();
            cycle();
        end
        valid_in = 1'b0; ready_in = 1'b1;
        repeat (10) cycle();
        checks++;
        if (obs_q.size() !== exp_q.size() || obs_q.size() == 0) begin
            errors++; $display("FAIL rand_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            o = obs_q[i]; e = exp_q[i];
            checks++;
            if (o !== e) begin errors++; $display("FAIL rand_beat%0d got=%h want=%h", i, o, e); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_diagonal_latency();
        test_directed_values();
        test_backpressure();
        test_config_sampling();
        test_reset_midstream();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shading_pipe.md
Name: shading_pipe

Overview:
- Pipelined, parametrised Lambertian shading unit.
- Takes a surface normal and light direction (vec3, signed fixed point) per ray-march hit and produces a packed RGB pixel with programmable ambient level, base colour and background colour.
- Sits between the normal-estimation stage and the framebuffer writer.
- Adds valid/ready backpressure, a pass-through pixel tag and a fixed 4-cycle latency.

Parameters:
- DATA_WIDTH, 32: width of each vec3 component, signed.
- FRAC_BITS, 24: fractional bits of vec3 components (Q8.24 by default); must be ≥ 8.
- OUT_WIDTH, 24: packed RGB width; 3 channels of CH_W = OUT_WIDTH/3 bits. Default CH_W = 8; arithmetic below is written for CH_W = 8.
- TAG_WIDTH, 20: width of the opaque pixel tag carried alongside data.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_in  in  1  input beat valid
- ready_out  out  1  block can accept an input beat
- hit_in  in  1  1 = ray hit surface; 0 = miss (background)
- normal_vec  in  vec3 (3*DATA_WIDTH)  unit surface normal
- light_vec  in  vec3 (3*DATA_WIDTH)  unit direction to light
- tag_in  in  TAG_WIDTH  pixel tag
- ambient_lvl  in  8  ambient intensity 0..255
- base_color  in  OUT_WIDTH  surface RGB {R,G,B}
- bg_color  in  OUT_WIDTH  miss RGB {R,G,B}
- valid_out  out  1  output beat valid
- ready_in  in  1  downstream accepts output beat
- shade_out  out  OUT_WIDTH  shaded pixel {R[23:16],G[15:8],B[7:0]}
- tag_out  out  TAG_WIDTH  tag of shade_out

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - All stage valid bits cleared.
  - valid_out = 0, shade_out = 0, tag_out = 0.
  - Reset mid-stream discards all in-flight beats; no partial output emitted.
- Pipeline enable: adv = !valid_out || ready_in.
  - ready_out = adv (combinational).
  - All stages move together when adv = 1 and hold when adv = 0.
  - Input is accepted when valid_in && ready_out.
  - Pipeline bubbles are not compressed while stalled.
- Latency: an accepted beat appears on valid_out exactly 4 adv-cycles later. Throughput is 1 beat/cycle when ready_in is held high.
- Stall: while valid_out && !ready_in, shade_out and tag_out hold stable.
- ambient_lvl, base_color, bg_color, hit_in and tag are sampled at input acceptance and travel with the beat. Config changes affect only later-accepted beats.
- S1 (multiply): px = nx*lx, py = ny*ly, pz = nz*lz, each signed, 2*DATA_WIDTH bits.
- S2 (sum/clamp):
  - dot = (px+py+pz) >>> FRAC_BITS, arithmetic shift, 2*DATA_WIDTH+2 bits signed, no overflow.
  - d9 = 0 if dot < 0.
  - d9 = 256 if dot ≥ 2^FRAC_BITS.
  - Otherwise d9 = dot >> (FRAC_BITS-8), range 0..256, 9 bits.
- S3 (intensity):
  - inten = ambient_lvl + (((255-ambient_lvl)*d9) >> 8), range 0..255.
  - i9 = inten + inten[7], so 255 maps to 256.
- S4 (colour, registered output):
  - If hit: each channel c = (base_c * i9) >> 8.
  - If miss: shade_out = bg_color unchanged.
  - tag_out = tag of the beat.
- Boundaries:
  - ambient_lvl = 255 gives full base colour regardless of dot.
  - ambient_lvl = 0 with dot ≤ 0 gives black.
  - Non-unit vectors with dot > 1.0 saturate; no wrap.
  - Negative-component saturation is not required: inputs are assumed |component| ≤ 2^(DATA_WIDTH-1)-1.
  - Simultaneous output handshake and input accept in the same cycle is legal: full throughput.

Test Plan:
- Use ambient_lvl = 26 and base_color = 0xFFFFFF unless noted. All vector values are Q8.24.
1. Diagonal: N = L = (0, 0.707, 0.707) (0.707 = 0x00B4FDF3), hit = 1 → after 4 cycles valid_out = 1, shade_out = 0xFEFEFE.
2. Aligned: N = L = (0, 0, 1.0), base_color = 0xFF8040 → shade_out = 0xFF8040. Perpendicular N = (1,0,0), L = (0,1,0) → shade_out = 0x191919.
3. Backlight N = (0,0,1), L = (0,0,-1) → 0x191919. Miss (hit_in = 0) with bg_color = 0x203040 → 0x203040 regardless of vectors.
4. Backpressure: stream 8 beats with tags 0..7 at full rate and hold ready_in = 0 for 5 cycles mid-stream → ready_out drops, shade_out/tag_out stable while stalled, all 8 tags emerge in order, none lost or duplicated.
5. Config sampling: accept beat A with ambient 26, change ambient_lvl to 255 next cycle, accept beat B (perpendicular for both) → A = 0x191919, B = 0xFFFFFF.
6. Reset with 3 beats in flight → valid_out stays 0 for the next 5 cycles. The first beat accepted after reset appears with latency 4.
